grant_budget_ctrl: RTL and testbench

GRANT_BUDGET_CTRL -- requirements
Module: grant_budget_ctrl

---
 rtl/grant_budget_ctrl.sv | 162 ++++++++++++++++
 tb/tb_grant_budget_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_budget_ctrl.sv
// Homa receiver grant pacer: pops SRPT grant requests and issues grants bounded by an
// overcommit byte budget, which is refilled as scheduled data packets arrive.
module grant_budget_ctrl #(
    parameter logic [31:0] OVERCOMMIT_BYTES = 32'd480000,
    parameter logic [31:0] MIN_GRANT_BYTES  = 32'h56a
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        grant_in_empty_i,
    output logic        grant_in_read_en_o,
    input  logic [96:0] grant_in_data_i,
    input  logic        grant_out_full_i,
    output logic        grant_out_write_en_o,
    output logic [96:0] grant_out_data_o,
    input  logic        data_rx_en_i,
    input  logic [31:0] data_rx_bytes_i,
    output logic [31:0] budget_avail_o,
    output logic [31:0] grants_issued_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EVAL,
        EMIT,
        WAIT_CREDIT
    } state_t;

    state_t      state_reg;
    logic        rd_en_reg;
    logic        wr_en_reg;
    logic [96:0] out_data_reg;
    logic [13:0] peer_reg;
    logic [15:0] rpc_reg;
    logic [31:0] req_reg;
    logic [31:0] grant_reg;
    logic [31:0] residual_reg;
    logic [31:0] outstanding_reg;
    logic [31:0] avail_reg;
    logic [31:0] issued_reg;

    logic        emit_fire;
    logic [32:0] sum_next;
    logic [32:0] rx_ext;
    logic [32:0] diff_next;
    logic [31:0] outstanding_next;
    logic [31:0] credit_floor;
    logic [31:0] credit_grant;
    logic        unused_data;

    // Bits outside peer/rpc/requested-bytes carry nothing this block uses.
    assign unused_data = ^{grant_in_data_i[96:94], grant_in_data_i[61:30]};

    function automatic logic [96:0] pack_grant(
        input logic [31:0] grant,
        input logic [15:0] rpc,
        input logic [13:0] peer
    );
        return {3'b000, grant, 32'd0, rpc, peer};
    endfunction

    assign emit_fire = (state_reg == EMIT) && !grant_out_full_i;

    // A grant committed and an arrival in the same cycle net out before saturating at zero.
    always_comb begin
        sum_next         = {1'b0, outstanding_reg} + (emit_fire ? {1'b0, grant_reg} : 33'd0);
        rx_ext           = data_rx_en_i ? {1'b0, data_rx_bytes_i} : 33'd0;
        diff_next        = sum_next - rx_ext;
        outstanding_next = (sum_next > rx_ext) ? diff_next[31:0] : 32'd0;
    end

    always_comb begin
        credit_floor = (residual_reg < MIN_GRANT_BYTES) ? residual_reg : MIN_GRANT_BYTES;
        credit_grant = (residual_reg < avail_reg) ? residual_reg : avail_reg;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            outstanding_reg <= 32'd0;
            avail_reg       <= OVERCOMMIT_BYTES;
        end else begin
            outstanding_reg <= outstanding_next;
            avail_reg       <= OVERCOMMIT_BYTES - outstanding_next;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg    <= IDLE;
            rd_en_reg    <= 1'b0;
            wr_en_reg    <= 1'b0;
            out_data_reg <= '0;
            peer_reg     <= '0;
            rpc_reg      <= '0;
            req_reg      <= '0;
            grant_reg    <= '0;
            residual_reg <= '0;
            issued_reg   <= '0;
        end else begin
            rd_en_reg <= 1'b0;
            wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!grant_in_empty_i) begin
                        rd_en_reg <= 1'b1;
                        state_reg <= READ;
                    end
                end
                // First READ cycle carries the pop; the FIFO word is valid in the second.
                READ: begin
                    if (!rd_en_reg) begin
                        peer_reg  <= grant_in_data_i[13:0];
                        rpc_reg   <= grant_in_data_i[29:14];
                        req_reg   <= grant_in_data_i[93:62];
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    if (req_reg == 32'd0) begin
                        state_reg <= IDLE;
                    end else if (req_reg <= avail_reg) begin
                        grant_reg    <= req_reg;
                        residual_reg <= 32'd0;
                        out_data_reg <= pack_grant(req_reg, rpc_reg, peer_reg);
                        state_reg    <= EMIT;
                    end else if (avail_reg >= MIN_GRANT_BYTES) begin
                        grant_reg    <= avail_reg;
                        residual_reg <= req_reg - avail_reg;
                        out_data_reg <= pack_grant(avail_reg, rpc_reg, peer_reg);
                        state_reg    <= EMIT;
                    end else begin
                        residual_reg <= req_reg;
                        state_reg    <= WAIT_CREDIT;
                    end
                end
                EMIT: begin
                    if (!grant_out_full_i) begin
                        wr_en_reg  <= 1'b1;
                        issued_reg <= issued_reg + 32'd1;
                        state_reg  <= (residual_reg != 32'd0) ? WAIT_CREDIT : IDLE;
                    end
                end
                WAIT_CREDIT: begin
                    if (avail_reg >= credit_floor) begin
                        grant_reg    <= credit_grant;
                        residual_reg <= residual_reg - credit_grant;
                        out_data_reg <= pack_grant(credit_grant, rpc_reg, peer_reg);
                        state_reg    <= EMIT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign grant_in_read_en_o   = rd_en_reg;
    assign grant_out_write_en_o = wr_en_reg;
    assign grant_out_data_o     = out_data_reg;
    assign budget_avail_o       = avail_reg;
    assign grants_issued_o      = issued_reg;

endmodule

// File: tb/tb_grant_budget_ctrl.sv
// Scoreboarded bench for grant_budget_ctrl: a byte-budget model predicts every grant
// write while a monitor checks what the controller actually emits.
module tb_grant_budget_ctrl;

    localparam logic [31:0] OC    = 32'd480000;
    localparam logic [31:0] MIN_G = 32'd1386;

    logic        clk;
    logic        rst_n;
    logic        grant_in_empty_i;
    logic        grant_in_read_en_o;
    logic [96:0] grant_in_data_i;
    logic        grant_out_full_i;
    logic        grant_out_write_en_o;
    logic [96:0] grant_out_data_o;
    logic        data_rx_en_i;
    logic [31:0] data_rx_bytes_i;
    logic [31:0] budget_avail_o;
    logic [31:0] grants_issued_o;

    grant_budget_ctrl #(
        .OVERCOMMIT_BYTES(OC),
        .MIN_GRANT_BYTES (MIN_G)
    ) dut (
        .ap_clk              (clk),
        .ap_rst_n            (rst_n),
        .grant_in_empty_i    (grant_in_empty_i),
        .grant_in_read_en_o  (grant_in_read_en_o),
        .grant_in_data_i     (grant_in_data_i),
        .grant_out_full_i    (grant_out_full_i),
        .grant_out_write_en_o(grant_out_write_en_o),
        .grant_out_data_o    (grant_out_data_o),
        .data_rx_en_i        (data_rx_en_i),
        .data_rx_bytes_i     (data_rx_bytes_i),
        .budget_avail_o      (budget_avail_o),
        .grants_issued_o     (grants_issued_o)
    );

    typedef struct {
        logic [96:0] data;
        logic [31:0] avail;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [96:0] fifo_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_rd_cyc = -1;
    int          last_wr_cyc = -1;
    int          n_reads = 0;
    bit          rd_allowed = 1'b1;
    bit          rand_full = 1'b0;

    // Reference model state: bytes granted but not yet received, pending residual.
    longint      m_out = 0;
    longint      m_res = 0;
    logic [31:0] m_cnt = '0;
    logic [13:0] m_peer = '0;
    logic [15:0] m_rpc = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h need 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input longint g, input longint rx);
        exp_t e;
        m_out = m_out + g - rx;
        if (m_out < 0) m_out = 0;
        m_cnt = m_cnt + 32'd1;
        e.data  = {3'b000, 32'(g), 32'd0, m_rpc, m_peer};
        e.avail = 32'(longint'(OC) - m_out);
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic model_request(input logic [13:0] peer, input logic [15:0] rpc,
                                 input longint req, input longint rx_at_write);
        longint avail;
        avail  = longint'(OC) - m_out;
        m_peer = peer;
        m_rpc  = rpc;
        if (req == 0) begin
            m_res = 0;
        end else if (req <= avail) begin
            m_res = 0;
            expect_grant(req, rx_at_write);
        end else if (avail >= longint'(MIN_G)) begin
            m_res = req - avail;
            expect_grant(avail, rx_at_write);
        end else begin
            m_res = req;
        end
    endtask

    task automatic model_rx(input longint rx);
        longint avail;
        longint floor_b;
        longint g;
        m_out = m_out - rx;
        if (m_out < 0) m_out = 0;
        while (m_res > 0) begin
            avail   = longint'(OC) - m_out;
            floor_b = (m_res < longint'(MIN_G)) ? m_res : longint'(MIN_G);
            if (avail < floor_b) break;
            g     = (m_res < avail) ? m_res : avail;
            m_res = m_res - g;
            expect_grant(g, 0);
        end
    endtask

    task automatic push_req(input logic [13:0] peer, input logic [15:0] rpc, input logic [31:0] req);
        logic [2:0]  junk_hi;
        logic [31:0] junk_mid;
        junk_hi  = 3'($urandom);
        junk_mid = $urandom;
        fifo_q.push_back({junk_hi, req, junk_mid, rpc, peer});
    endtask

    task automatic do_rx(input logic [31:0] bytes);
        @(negedge clk);
        data_rx_en_i    = 1'b1;
        data_rx_bytes_i = bytes;
        @(negedge clk);
        data_rx_en_i    = 1'b0;
        data_rx_bytes_i = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            if (rand_full) grant_out_full_i = ($urandom_range(0, 3) == 0);
            n++;
        end
        grant_out_full_i = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d grants never written after %0d cycles (need 0 left)", name, exp_q.size(), n);
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    // Request FIFO with one-cycle read latency.
    initial begin : fifo_model
        bit pop;
        grant_in_empty_i = 1'b1;
        grant_in_data_i  = '0;
        forever begin
            @(negedge clk);
            pop = rst_n && grant_in_read_en_o;
            @(posedge clk);
            #1;
            if (pop && fifo_q.size() != 0) grant_in_data_i = fifo_q.pop_front();
            grant_in_empty_i = (fifo_q.size() == 0);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (grant_in_read_en_o) begin
                    n_reads++;
                    last_rd_cyc = cyc;
                    check("read_allowed", {grant_out_write_en_o, grant_in_empty_i, !rd_allowed}, 3'b000);
                end
                if (grant_out_write_en_o) begin
                    last_wr_cyc = cyc;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write: got data 0x%0h need no write", grant_out_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_data", grant_out_data_o, e.data);
                        check("grant_budget", budget_avail_o, e.avail);
                        check("grant_count", grants_issued_o, e.cnt);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int drop_cyc;
        int reads_before;
        logic [13:0] peer;
        logic [15:0] rpc;
        logic [31:0] req;
        logic [31:0] rx;
        int guard;

        grant_out_full_i = 1'b0;
        data_rx_en_i     = 1'b0;
        data_rx_bytes_i  = '0;
        rst_n            = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_read_en", grant_in_read_en_o, 0);
        check("rst_write_en", grant_out_write_en_o, 0);
        check("rst_data", grant_out_data_o, 0);
        check("rst_budget", budget_avail_o, OC);
        check("rst_grants", grants_issued_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request with a full budget.
        push_req(14'd1, 16'd1, 32'd60000);
        model_request(14'd1, 16'd1, 60000, 0);
        wait_drain("first_grant");
        check("read_to_write_latency", 97'(last_wr_cyc - last_rd_cyc), 97'(4));
        check("budget_after_first", budget_avail_o, 32'd420000);

        // Exhaust the budget, then a ninth request must wait for credit.
        for (int i = 2; i <= 8; i++) begin
            push_req(14'(i), 16'(i * 3), 32'd60000);
            model_request(14'(i), 16'(i * 3), 60000, 0);
            wait_drain("fill_budget");
        end
        check("budget_exhausted", budget_avail_o, 0);
        push_req(14'd9, 16'd99, 32'd60000);
        model_request(14'd9, 16'd99, 60000, 0);
        wait_drain("ninth_waits");
        rd_allowed = 1'b0;
        push_req(14'd10, 16'd100, 32'd5000);
        repeat (12) @(negedge clk);
        model_rx(1386);
        do_rx(32'd1386);
        wait_drain("credit_1386");
        rd_allowed = 1'b1;
        model_rx(58614);
        model_request(14'd10, 16'd100, 5000, 0);
        do_rx(32'd58614);
        wait_drain("credit_residual");
        model_rx(480000);
        do_rx(32'd480000);
        wait_drain("tenth_after_credit");

        // Partial grant with avail=100000, then the remainder after credit.
        push_req(14'd11, 16'd110, 32'd375000);
        model_request(14'd11, 16'd110, 375000, 0);
        wait_drain("set_avail_100000");
        check("avail_100000", budget_avail_o, 32'd100000);
        push_req(14'd12, 16'd120, 32'd150000);
        model_request(14'd12, 16'd120, 150000, 0);
        wait_drain("partial_grant");
        model_rx(50000);
        do_rx(32'd50000);
        wait_drain("remainder_grant");
        model_rx(500000);
        do_rx(32'd500000);
        check("rx_saturates", budget_avail_o, OC);

        // Egress back-pressure, releasing it together with an arrival.
        push_req(14'd13, 16'd130, 32'd1000);
        model_request(14'd13, 16'd130, 1000, 0);
        wait_drain("outstanding_1000");
        grant_out_full_i = 1'b1;
        push_req(14'd14, 16'd140, 32'd5000);
        model_request(14'd14, 16'd140, 5000, 2000);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_no_write", grant_out_write_en_o, 0);
            check("hold_data_stable", grant_out_data_o, (exp_q.size() != 0) ? exp_q[0].data : 97'd0);
        end
        grant_out_full_i = 1'b0;
        data_rx_en_i     = 1'b1;
        data_rx_bytes_i  = 32'd2000;
        drop_cyc         = cyc;
        @(negedge clk);
        data_rx_en_i     = 1'b0;
        data_rx_bytes_i  = '0;
        wait_drain("write_after_full");
        check("write_after_full_drop", 97'(last_wr_cyc), 97'(drop_cyc + 1));
        check("combined_outstanding", budget_avail_o, OC - 32'd4000);
        model_rx(9000);
        do_rx(32'd9000);
        check("saturate_9000", budget_avail_o, 32'(longint'(OC) - m_out));

        // Randomized requests, credits and egress stalls.
        rand_full = 1'b1;
        for (int n = 0; n < 40; n++) begin
            peer = 14'($urandom);
            rpc  = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       req = 32'd0;
                1, 2:    req = $urandom_range(1, 2000);
                3, 4, 5: req = $urandom_range(1000, 120000);
                default: req = $urandom_range(100000, 400000);
            endcase
            push_req(peer, rpc, req);
            model_request(peer, rpc, longint'(req), 0);
            wait_drain("rand_req");
            if ($urandom_range(0, 1) == 1) begin
                rx = $urandom_range(0, 150000);
                model_rx(longint'(rx));
                do_rx(rx);
                wait_drain("rand_rx");
            end
            guard = 0;
            while (m_res > 0 && guard < 40) begin
                rx = $urandom_range(500, 60000);
                model_rx(longint'(rx));
                do_rx(rx);
                wait_drain("rand_credit");
                guard++;
            end
            if (m_res > 0) begin
                model_rx(longint'(OC));
                do_rx(OC);
                wait_drain("rand_flush");
            end
            check("rand_budget", budget_avail_o, 32'(longint'(OC) - m_out));
        end
        rand_full = 1'b0;

        // Reset while waiting for credit.
        model_rx(longint'(OC));
        do_rx(OC);
        wait_drain("pre_reset_clear");
        push_req(14'd20, 16'd200, 32'd479500);
        model_request(14'd20, 16'd200, 479500, 0);
        wait_drain("pre_reset_fill");
        push_req(14'd21, 16'd210, 32'd3000);
        model_request(14'd21, 16'd210, 3000, 0);
        wait_drain("enter_wait_credit");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_read_en", grant_in_read_en_o, 0);
        check("async_rst_write_en", grant_out_write_en_o, 0);
        check("async_rst_data", grant_out_data_o, 0);
        check("async_rst_budget", budget_avail_o, OC);
        check("async_rst_grants", grants_issued_o, 0);
        m_out = 0;
        m_res = 0;
        m_cnt = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        reads_before = n_reads;
        push_req(14'd22, 16'd220, 32'd2000);
        model_request(14'd22, 16'd220, 2000, 0);
        wait_drain("post_reset_grant");
        check("post_reset_one_read", 97'(n_reads), 97'(reads_before + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
